maze_level_ctrl: RTL and testbench
==================================

Name: maze_level_ctrl

Overview:
- Sequences gameplay over the maze wall layout: holds the current level, publishes that level's wall-enable mask, and after each frame `update` tick scans every wall descriptor against the player box.
- Resolves each scan to a hit (lose a life, request respawn), goal reached (advance level or win), or nothing.
- Sits between the wall pixel generator, the player-position logic and the top-level display/score logic.

Parameters:
- NUM_WALLS, 26, number of wall descriptor slots per level.
- NUM_LEVELS, 2, number of levels; the level counter is clog2(NUM_LEVELS) bits, min 1.
- PLAYER_SZ, 10, player box edge in pixels.
- LIVES, 3, lives loaded at start.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- update  in  1  one-cycle frame tick, synchronous to clk
- start  in  1  one-cycle start request
- player_x  in  10  player box left edge
- player_y  in  10  player box top edge
- level  out  LVW  current level index
- wall_en  out  NUM_WALLS  enable mask for the current level
- lives  out  2  remaining lives
- state  out  3  FSM state code
- busy  out  1  high while scanning
- hit  out  1  one-cycle collision pulse
- respawn  out  1  one-cycle pulse; player logic returns the player to the start position
- level_done  out  1  one-cycle goal pulse
- game_won  out  1  level, sticky until rst or start
- game_over  out  1  level, sticky until rst or start

Behaviour:
- Reset (rst=1 on a clk edge) forces every output to its reset value, including mid-scan:
  - state=IDLE, level=0, lives=0, wall_en=0, busy=0;
  - all pulses 0, game_won=0, game_over=0;
  - scan index=0, hit flag cleared.
- FSM codes: IDLE=0, PLAY=1, SCAN=2, RESOLVE=3, WIN=4, OVER=5.
- IDLE/WIN/OVER + start:
  - go to PLAY;
  - level=0, lives=LIVES, wall_en=mask(0);
  - clear game_won and game_over.
- PLAY + update in cycle t: go to SCAN at t+1; index=0; hit flag=0; busy=1.
- SCAN:
  - Index k is evaluated in cycle t+1+k, one descriptor per cycle, always the full NUM_WALLS entries (no early exit).
  - Descriptor fields: x(10), y(9), w(10), h(9), en(1).
  - Overlap test uses 11-bit unsigned arithmetic (no wrap):
    - (px+PLAYER_SZ-1 > x) and (px < x+w) and (py+PLAYER_SZ-1 > y) and (py < y+h).
    - Strict inequalities match the generator's exclusive pixel bounds.
  - en=0 entries never hit. Any hit sets a sticky hit flag.
  - player_x/player_y are sampled once at t+1 and held for the whole scan.
- RESOLVE (cycle t+NUM_WALLS+1). Pulses are registered and high at t+NUM_WALLS+2:
  - Hit flag set: hit=1, respawn=1, lives-1.
    - If lives was 1: state becomes OVER, game_over=1.
    - Otherwise: state becomes PLAY.
  - Else if the player box lies entirely inside the level's goal rectangle (inclusive bounds): level_done=1.
    - If last level: state becomes WIN, game_won=1.
    - Otherwise: level+1, wall_en=mask(level+1), state becomes PLAY.
  - Else: state becomes PLAY.
  - Hit has priority over goal when both apply.
- update while in SCAN, RESOLVE, IDLE, WIN or OVER: ignored, not queued.
- start while in PLAY, SCAN or RESOLVE: ignored.
- wall_en changes only on start or level advance. It is stable throughout a frame.

Decomposition:
- Shared package maze_pkg:
  - NUM_WALLS and NUM_LEVELS constants;
  - FSM state encoding;
  - wall descriptor field widths and the packed descriptor layout {x,y,w,h,en};
  - goal rectangle layout.
- Sub-module maze_layout_rom: combinational lookup (level, index) -> descriptor, plus level -> goal rectangle and level -> wall_en mask.
- Level 0 content is the current 26-wall layout with all enables set. Example entries:
  - entry 0: x=5, y=46, w=600, h=20;
  - entry 3: x=150, y=100, w=20, h=120.
- Level 0 goal: x=560..600, y=420..460.

Test Plan:
- rst mid-SCAN at cycle t+5 -> next cycle state=0, busy=0, lives=0, no hit/level_done pulse ever emitted for that frame.
- start, then update with player at (100,50) -> busy=1 for cycles t+1..t+26; hit=respawn=1 exactly at t+28; lives 3->2; state=PLAY.
- Edge case on entry 3 with player_y=150: player_x=141 (right edge 150) -> no hit; player_x=142 -> hit pulse.
- Player at (570,430), no overlap -> level_done at t+28, level 0->1, wall_en=mask(1). Repeat on level 1 goal -> game_won=1, state=WIN.
- Three colliding frames from lives=3 -> lives 0, game_over=1, state=OVER; a further update produces no pulses; start returns to PLAY with lives=3, level=0.
- update asserted again at t+10 during SCAN -> ignored: exactly one RESOLVE and one set of pulses for the frame.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared constants and types for the maze level controller and its layout ROM.
package maze_pkg;
  localparam int NUM_WALLS  = 26;
  localparam int NUM_LEVELS = 2;
  localparam int LVW        = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int IDXW       = $clog2(NUM_WALLS);

  localparam int WX_W = 10;
  localparam int WY_W = 9;
  localparam int WW_W = 10;
  localparam int WH_W = 9;
  localparam int GC_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_SCAN    = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_WIN     = 3'd4,
    ST_OVER    = 3'd5
  } state_e;

  typedef struct packed {
    logic [WX_W-1:0] x;
    logic [WY_W-1:0] y;
    logic [WW_W-1:0] w;
    logic [WH_W-1:0] h;
    logic            en;
  } wall_desc_t;

  // Inclusive goal bounds.
  typedef struct packed {
    logic [GC_W-1:0] x0;
    logic [GC_W-1:0] y0;
    logic [GC_W-1:0] x1;
    logic [GC_W-1:0] y1;
  } goal_rect_t;
endpackage

// File: rtl/maze_layout_rom.sv
// Combinational maze layout: per-level wall descriptors, goal rectangle and wall enable mask.
module maze_layout_rom
  import maze_pkg::*;
(
  input  logic [LVW-1:0]       level,
  input  logic [IDXW-1:0]      idx,
  input  logic [LVW-1:0]       mask_level,
  output wall_desc_t           desc,
  output goal_rect_t           goal,
  output logic [NUM_WALLS-1:0] mask
);
  // Level 1 reuses the level 0 geometry with a few interior walls opened up.
  function automatic logic [NUM_WALLS-1:0] level_mask(input logic [LVW-1:0] lvl);
    logic [NUM_WALLS-1:0] m;
    m = '1;
    if (lvl == LVW'(1)) m = 26'h3FF_D55F;
    return m;
  endfunction

  logic [NUM_WALLS-1:0] cur_mask;
  wall_desc_t           base;

  always_comb begin
    base = '0;
    case (idx)
      5'd0:  base = '{10'd5,   9'd46,  10'd600, 9'd20,  1'b0};
      5'd1:  base = '{10'd5,   9'd465, 10'd600, 9'd10,  1'b0};
      5'd2:  base = '{10'd5,   9'd46,  10'd15,  9'd429, 1'b0};
      5'd3:  base = '{10'd150, 9'd100, 10'd20,  9'd120, 1'b0};
      5'd4:  base = '{10'd610, 9'd46,  10'd15,  9'd429, 1'b0};
      5'd5:  base = '{10'd60,  9'd120, 10'd80,  9'd15,  1'b0};
      5'd6:  base = '{10'd250, 9'd66,  10'd20,  9'd150, 1'b0};
      5'd7:  base = '{10'd350, 9'd150, 10'd20,  9'd200, 1'b0};
      5'd8:  base = '{10'd450, 9'd66,  10'd20,  9'd180, 1'b0};
      5'd9:  base = '{10'd520, 9'd150, 10'd90,  9'd15,  1'b0};
      5'd10: base = '{10'd20,  9'd250, 10'd120, 9'd15,  1'b0};
      5'd11: base = '{10'd200, 9'd250, 10'd150, 9'd15,  1'b0};
      5'd12: base = '{10'd400, 9'd300, 10'd130, 9'd15,  1'b0};
      5'd13: base = '{10'd100, 9'd320, 10'd20,  9'd100, 1'b0};
      5'd14: base = '{10'd200, 9'd350, 10'd20,  9'd115, 1'b0};
      5'd15: base = '{10'd300, 9'd400, 10'd150, 9'd15,  1'b0};
      5'd16: base = '{10'd480, 9'd350, 10'd20,  9'd115, 1'b0};
      5'd17: base = '{10'd550, 9'd250, 10'd60,  9'd15,  1'b0};
      5'd18: base = '{10'd20,  9'd380, 10'd60,  9'd10,  1'b0};
      5'd19: base = '{10'd260, 9'd300, 10'd80,  9'd15,  1'b0};
      5'd20: base = '{10'd170, 9'd180, 10'd40,  9'd10,  1'b0};
      5'd21: base = '{10'd380, 9'd100, 10'd50,  9'd15,  1'b0};
      5'd22: base = '{10'd300, 9'd200, 10'd40,  9'd15,  1'b0};
      5'd23: base = '{10'd560, 9'd330, 10'd45,  9'd15,  1'b0};
      5'd24: base = '{10'd130, 9'd420, 10'd50,  9'd15,  1'b0};
      5'd25: base = '{10'd400, 9'd440, 10'd60,  9'd25,  1'b0};
      default: base = '0;
    endcase

    cur_mask = level_mask(level);
    desc     = base;
    desc.en  = cur_mask[idx];

    goal = '{10'd560, 10'd420, 10'd600, 10'd460};
    if (level == LVW'(1)) goal = '{10'd30, 10'd420, 10'd70, 10'd460};

    mask = level_mask(mask_level);
  end
endmodule

// File: rtl/maze_level_ctrl.sv
// Gameplay sequencer: per-frame wall scan against the player box, then hit/goal resolution.
module maze_level_ctrl
  import maze_pkg::*;
#(
  parameter int PLAYER_SZ = 10,
  parameter int LIVES     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 update,
  input  logic                 start,
  input  logic [9:0]           player_x,
  input  logic [9:0]           player_y,
  output logic [LVW-1:0]       level,
  output logic [NUM_WALLS-1:0] wall_en,
  output logic [1:0]           lives,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 hit,
  output logic                 respawn,
  output logic                 level_done,
  output logic                 game_won,
  output logic                 game_over
);
  state_e               state_q, state_d;
  logic [LVW-1:0]       level_q, level_d;
  logic [1:0]           lives_q, lives_d;
  logic [NUM_WALLS-1:0] wall_en_q, wall_en_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic                 hit_flag_q, hit_flag_d;
  logic [9:0]           px_q, px_d, py_q, py_d;
  logic                 hit_q, hit_d, respawn_q, respawn_d, level_done_q, level_done_d;
  logic                 game_won_q, game_won_d, game_over_q, game_over_d;

  wall_desc_t           desc;
  goal_rect_t           goal;
  logic [NUM_WALLS-1:0] rom_mask;
  logic [LVW-1:0]       mask_level;

  // The mask lookup only matters on start (level 0) or on a level advance from RESOLVE.
  assign mask_level = (state_q == ST_RESOLVE) ? level_q + LVW'(1) : '0;

  maze_layout_rom u_rom (
    .level      (level_q),
    .idx        (idx_q),
    .mask_level (mask_level),
    .desc       (desc),
    .goal       (goal),
    .mask       (rom_mask)
  );

  // Index 0 uses the live position; it is latched there and held for the rest of the scan.
  logic [9:0]  px_eff, py_eff;
  logic [10:0] p_right, p_bottom, w_right, w_bottom, g_right, g_bottom;
  logic        overlap, in_goal;

  assign px_eff   = (idx_q == '0) ? player_x : px_q;
  assign py_eff   = (idx_q == '0) ? player_y : py_q;
  assign p_right  = {1'b0, px_eff} + 11'(PLAYER_SZ - 1);
  assign p_bottom = {1'b0, py_eff} + 11'(PLAYER_SZ - 1);
  assign w_right  = {1'b0, desc.x} + {1'b0, desc.w};
  assign w_bottom = {2'b0, desc.y} + {2'b0, desc.h};
  assign overlap  = desc.en && (p_right > {1'b0, desc.x}) && ({1'b0, px_eff} < w_right) &&
                    (p_bottom > {2'b0, desc.y}) && ({1'b0, py_eff} < w_bottom);

  assign g_right  = {1'b0, px_q} + 11'(PLAYER_SZ - 1);
  assign g_bottom = {1'b0, py_q} + 11'(PLAYER_SZ - 1);
  assign in_goal  = (px_q >= goal.x0) && (g_right <= {1'b0, goal.x1}) &&
                    (py_q >= goal.y0) && (g_bottom <= {1'b0, goal.y1});

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    lives_d      = lives_q;
    wall_en_d    = wall_en_q;
    idx_d        = idx_q;
    hit_flag_d   = hit_flag_q;
    px_d         = px_q;
    py_d         = py_q;
    hit_d        = 1'b0;
    respawn_d    = 1'b0;
    level_done_d = 1'b0;
    game_won_d   = game_won_q;
    game_over_d  = game_over_q;

    case (state_q)
      ST_IDLE, ST_WIN, ST_OVER: begin
        if (start) begin
          state_d     = ST_PLAY;
          level_d     = '0;
          lives_d     = 2'(LIVES);
          wall_en_d   = rom_mask;
          game_won_d  = 1'b0;
          game_over_d = 1'b0;
        end
      end
      ST_PLAY: begin
        if (update) begin
          state_d    = ST_SCAN;
          idx_d      = '0;
          hit_flag_d = 1'b0;
        end
      end
      ST_SCAN: begin
        hit_flag_d = hit_flag_q | overlap;
        if (idx_q == '0) begin
          px_d = player_x;
          py_d = player_y;
        end
        if (idx_q == IDXW'(NUM_WALLS - 1)) state_d = ST_RESOLVE;
        else                               idx_d   = idx_q + IDXW'(1);
      end
      ST_RESOLVE: begin
        state_d = ST_PLAY;
        if (hit_flag_q) begin
          hit_d     = 1'b1;
          respawn_d = 1'b1;
          lives_d   = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            state_d     = ST_OVER;
            game_over_d = 1'b1;
          end
        end else if (in_goal) begin
          level_done_d = 1'b1;
          if (level_q == LVW'(NUM_LEVELS - 1)) begin
            state_d    = ST_WIN;
            game_won_d = 1'b1;
          end else begin
            level_d   = level_q + LVW'(1);
            wall_en_d = rom_mask;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      lives_q      <= '0;
      wall_en_q    <= '0;
      idx_q        <= '0;
      hit_flag_q   <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      hit_q        <= 1'b0;
      respawn_q    <= 1'b0;
      level_done_q <= 1'b0;
      game_won_q   <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      wall_en_q    <= wall_en_d;
      idx_q        <= idx_d;
      hit_flag_q   <= hit_flag_d;
      px_q         <= px_d;
      py_q         <= py_d;
      hit_q        <= hit_d;
      respawn_q    <= respawn_d;
      level_done_q <= level_done_d;
      game_won_q   <= game_won_d;
      game_over_q  <= game_over_d;
    end
  end

  assign level      = level_q;
  assign wall_en    = wall_en_q;
  assign lives      = lives_q;
  assign state      = state_q;
  assign busy       = (state_q == ST_SCAN);
  assign hit        = hit_q;
  assign respawn    = respawn_q;
  assign level_done = level_done_q;
  assign game_won   = game_won_q;
  assign game_over  = game_over_q;
endmodule

// File: tb/tb_maze_level_ctrl.sv
// Directed, table-driven bench for maze_level_ctrl with hand-computed expectations.
module tb_maze_level_ctrl;
  localparam int NW = 26;
  localparam logic [25:0] M0 = 26'h3FF_FFFF;
  localparam logic [25:0] M1 = 26'h3FF_D55F;

  logic        clk, rst, update, start;
  logic [9:0]  player_x, player_y;
  logic [0:0]  level;
  logic [25:0] wall_en;
  logic [1:0]  lives;
  logic [2:0]  state;
  logic        busy, hit, respawn, level_done, game_won, game_over;

  int n_checks = 0;
  int n_fail   = 0;

  logic        cap_hit, cap_resp, cap_done, cap_won, cap_over;
  logic [2:0]  cap_state;
  logic [1:0]  cap_lives;
  logic [0:0]  cap_level;
  logic [25:0] cap_wall;

  maze_level_ctrl dut (
    .clk(clk), .rst(rst), .update(update), .start(start),
    .player_x(player_x), .player_y(player_y),
    .level(level), .wall_en(wall_en), .lives(lives), .state(state), .busy(busy),
    .hit(hit), .respawn(respawn), .level_done(level_done),
    .game_won(game_won), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          do_start;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        exp_hit;
    logic        exp_done;
    logic [2:0]  exp_state;
    logic [1:0]  exp_lives;
    logic [0:0]  exp_level;
    logic        exp_won;
    logic        exp_over;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one frame tick and follows it through scan, resolve and the pulse cycle.
  task automatic run_frame(input logic [9:0] px, input logic [9:0] py);
    int bad;
    player_x = px;
    player_y = py;
    update = 1'b1;
    step();
    update = 1'b0;
    bad = 0;
    for (int k = 1; k <= NW; k++) begin
      if (!(busy === 1'b1 && state === 3'd2 && hit === 1'b0 &&
            respawn === 1'b0 && level_done === 1'b0)) bad++;
      if (k < NW) step();
    end
    check("scan_window", 32'(bad), 32'd0);
    step();
    check("resolve_state", 32'(state), 32'd3);
    check("resolve_quiet", 32'({busy, hit, respawn, level_done}), 32'd0);
    step();
    cap_hit = hit; cap_resp = respawn; cap_done = level_done;
    cap_state = state; cap_lives = lives; cap_level = level;
    cap_won = game_won; cap_over = game_over; cap_wall = wall_en;
    step();
    check("pulse_clear", 32'({hit, respawn, level_done}), 32'd0);
  endtask

  initial begin
    int bad, n_res, n_hit;
    rst = 1'b1; update = 1'b0; start = 1'b0; player_x = '0; player_y = '0;

    vecs[0] = '{1'b1, 10'd100, 10'd50,  1'b1, 1'b0, 3'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 10'd141, 10'd150, 1'b0, 1'b0, 3'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 10'd142, 10'd150, 1'b1, 1'b0, 3'd1, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 10'd570, 10'd430, 1'b0, 1'b1, 3'd1, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 10'd40,  10'd430, 1'b0, 1'b1, 3'd4, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 10'd100, 10'd50,  1'b1, 1'b0, 3'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 10'd100, 10'd50,  1'b1, 1'b0, 3'd1, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 10'd100, 10'd50,  1'b1, 1'b0, 3'd5, 2'd0, 1'b0, 1'b0, 1'b1};

    step(); step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_lives_level", 32'({lives, level}), 32'd0);
    check("rst_wall_en", 32'(wall_en), 32'd0);
    check("rst_flags", 32'({busy, hit, respawn, level_done, game_won, game_over}), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_start) begin
        start = 1'b1;
        step();
        start = 1'b0;
        check($sformatf("v%0d_start_state", i), 32'(state), 32'd1);
        check($sformatf("v%0d_start_lives", i), 32'(lives), 32'd3);
        check($sformatf("v%0d_start_level", i), 32'(level), 32'd0);
        check($sformatf("v%0d_start_wall", i), 32'(wall_en), 32'(M0));
        check($sformatf("v%0d_start_sticky", i), 32'({game_won, game_over}), 32'd0);
      end
      run_frame(vecs[i].px, vecs[i].py);
      check($sformatf("v%0d_hit", i), 32'(cap_hit), 32'(vecs[i].exp_hit));
      check($sformatf("v%0d_respawn", i), 32'(cap_resp), 32'(vecs[i].exp_hit));
      check($sformatf("v%0d_level_done", i), 32'(cap_done), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_state", i), 32'(cap_state), 32'(vecs[i].exp_state));
      check($sformatf("v%0d_lives", i), 32'(cap_lives), 32'(vecs[i].exp_lives));
      check($sformatf("v%0d_level", i), 32'(cap_level), 32'(vecs[i].exp_level));
      check($sformatf("v%0d_won", i), 32'(cap_won), 32'(vecs[i].exp_won));
      check($sformatf("v%0d_over", i), 32'(cap_over), 32'(vecs[i].exp_over));
      check($sformatf("v%0d_wall_en", i), 32'(cap_wall),
            32'((vecs[i].exp_level == 1'b1) ? M1 : M0));
    end

    // update in OVER is ignored
    update = 1'b1;
    step();
    update = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (state !== 3'd5 || hit !== 1'b0 || respawn !== 1'b0 || level_done !== 1'b0) bad++;
      step();
    end
    check("over_update_ignored", 32'(bad), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_state", 32'(state), 32'd1);
    check("restart_lives_level", 32'({lives, level}), 32'({2'd3, 1'b0}));
    check("restart_over_cleared", 32'({game_won, game_over}), 32'd0);

    // second update during SCAN is not queued
    player_x = 10'd100; player_y = 10'd50;
    update = 1'b1;
    step();
    update = 1'b0;
    for (int k = 0; k < 9; k++) step();
    update = 1'b1;
    step();
    update = 1'b0;
    n_res = 0; n_hit = 0;
    for (int k = 0; k < 60; k++) begin
      if (state === 3'd3) n_res++;
      if (hit === 1'b1) n_hit++;
      step();
    end
    check("dbl_update_resolves", 32'(n_res), 32'd1);
    check("dbl_update_hits", 32'(n_hit), 32'd1);
    check("dbl_update_lives", 32'(lives), 32'd2);
    check("dbl_update_state", 32'(state), 32'd1);

    // reset mid-scan
    update = 1'b1;
    step();
    update = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_busy_lives", 32'({busy, lives}), 32'd0);
    check("midrst_wall_level", 32'({wall_en, level}), 32'd0);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      if (hit !== 1'b0 || respawn !== 1'b0 || level_done !== 1'b0 || state !== 3'd0) bad++;
      step();
    end
    check("midrst_no_pulses", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
